user_rom_reader: RTL
====================

USER_ROM_READER -- requirements
Module: user_rom_reader

Interface
REQ-001 Parameter MaxWords, default 8: maximum number of 32-bit words fetched per transfer; SHALL be a power of two, at least 2.
REQ-002 Parameter IdWidth, default 1: width of the OBI request ID.
REQ-003 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 start_i  in  1  one-cycle pulse that begins a transfer.
REQ-006 abort_i  in  1  request to end the current transfer early.
REQ-007 base_addr_i  in  32  byte address of the string; sampled when start_i is accepted.
REQ-008 busy_o  out  1  high while a transfer is in progress.
REQ-009 done_o  out  1  one-cycle pulse at the end of every transfer.
REQ-010 err_o  out  1  one-cycle pulse, coincident with done_o, when the transfer ended on an OBI error.
REQ-011 count_o  out  $clog2(4*MaxWords+1)  number of bytes emitted; held stable until the next start.
REQ-012 byte_o / byte_valid_o / byte_ready_i  out 8 / out 1 / in 1  output byte stream with a valid/ready handshake.
REQ-013 obi_req_o, obi_we_o, obi_be_o[3:0], obi_addr_o[31:0], obi_aid_o[IdWidth-1:0]  out  OBI manager A channel.
REQ-014 obi_gnt_i, obi_rvalid_i, obi_rdata_i[31:0], obi_err_i  in  OBI grant and R channel.

Function
REQ-015 FSM states are IDLE, REQ, WAIT, EMIT and DONE; the machine SHALL leave reset in IDLE.
REQ-016 IDLE: start_i=1 SHALL latch {base_addr_i[31:2],2'b00}, clear the word counter, byte index and count_o, then go to REQ; start_i is ignored in every other state.
REQ-017 REQ: obi_req_o=1, obi_we_o=0, obi_be_o=4'hF, obi_aid_o=0, obi_addr_o = base + 4*word_cnt (mod 2^32); the A-channel outputs SHALL stay stable until obi_gnt_i=1, which moves the FSM to WAIT.
REQ-018 obi_req_o SHALL be 0 in every state except REQ, with at most one transaction outstanding.
REQ-019 WAIT: obi_rvalid_i is sampled only in this state; rvalid with err=1 goes to DONE with the error flag set; rvalid with err=0 latches rdata, sets byte index to 0 and goes to EMIT.
REQ-020 EMIT: byte_o = word[8*idx+7:8*idx], i.e. little-endian with byte 0 first.
REQ-021 EMIT, NUL byte: byte_valid_o SHALL stay 0 and the FSM goes to DONE; the NUL byte is not counted.
REQ-022 EMIT, non-NUL byte: byte_valid_o=1; byte_o SHALL be held stable while byte_ready_i=0.
REQ-023 EMIT, handshake (valid and ready): count_o increments; if idx<3 then idx increments; if idx==3 the word counter increments and the FSM goes to DONE when word_cnt==MaxWords-1, otherwise to REQ.
REQ-024 DONE: done_o=1 for exactly one cycle, err_o=1 in the same cycle when the error flag is set, then the FSM returns to IDLE.
REQ-025 busy_o=1 in REQ, WAIT, EMIT and DONE; busy_o=0 in IDLE.
REQ-026 abort_i in EMIT SHALL go to DONE on the next edge; any handshake in that same cycle still counts.
REQ-027 abort_i in REQ or WAIT SHALL set an abort flag; the current transaction completes (gnt, then rvalid), after which the FSM goes to DONE without emitting any bytes.
REQ-028 abort_i in IDLE or DONE SHALL have no effect; the abort flag clears on entry to IDLE.
REQ-029 A transfer that reads MaxWords words with no NUL SHALL end with count_o = 4*MaxWords.
REQ-030 The OBI error response SHALL take priority over an abort in the same cycle: err_o=1.

Reset
REQ-031 rst_i=1 at a clock edge SHALL force the FSM to IDLE and clear the word counter, byte index, data and abort/error flags, with count_o=0, in any state including mid-transaction.
REQ-032 During and immediately after reset, all outputs SHALL be 0: obi_req_o, obi_we_o, obi_be_o, obi_addr_o, obi_aid_o, byte_o, byte_valid_o, busy_o, done_o and err_o.
REQ-033 After reset the OBI subordinate is assumed to drop any outstanding response, so no rvalid handling is required.

Verification
REQ-034 Normal read: ROM words 0x656D7544, 0x4326696E, 0x69726465, 0x20732763, 0x43495341, 0x2E307620, 0x00302E31, 0x0; start with base 0x0 and ready=1 -> bytes 0x44, 0x75, 0x6D, 0x65, ..., 0x31, 0x2E, 0x30; done_o with count_o=27; 7 OBI requests at addresses 0x00 to 0x18.
REQ-035 No NUL: all words 0x41414141, MaxWords=8 -> 32 bytes of 0x41, count_o=32, exactly 8 requests, last address base+0x1C.
REQ-036 Backpressure and grant stalls: byte_ready_i toggled pseudo-randomly and obi_gnt_i delayed 0-3 cycles -> byte_o and A-channel outputs stable while stalled; stream identical to REQ-034.
REQ-037 Error: obi_err_i=1 on the rvalid for word 2 -> done_o and err_o pulse together, count_o=8, no further requests.
REQ-038 Abort in WAIT: abort_i pulsed the cycle after gnt of word 0 -> rvalid consumed, no bytes emitted, done_o with count_o=0.
REQ-039 Reset mid-EMIT: rst_i pulsed at byte 5 -> all outputs 0 on the next cycle; a new start with base 0x0 reproduces REQ-034 exactly.

Source files
------------

// File: rtl/user_rom_reader.sv
`default_nettype none
// ============================================================================
//  Module      : user_rom_reader
//  Description : Fetches a NUL-terminated string from memory over an OBI
//                manager port, one 32-bit word at a time, and streams its
//                bytes out little-endian on a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module user_rom_reader #(
    parameter int unsigned MaxWords = 8,
    parameter int unsigned IdWidth  = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic                               abort_i,
    input  logic [31:0]                        base_addr_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic [$clog2(4*MaxWords+1)-1:0]    count_o,
    output logic [7:0]                         byte_o,
    output logic                               byte_valid_o,
    input  logic                               byte_ready_i,
    output logic                               obi_req_o,
    output logic                               obi_we_o,
    output logic [3:0]                         obi_be_o,
    output logic [31:0]                        obi_addr_o,
    output logic [IdWidth-1:0]                 obi_aid_o,
    input  logic                               obi_gnt_i,
    input  logic                               obi_rvalid_i,
    input  logic [31:0]                        obi_rdata_i,
    input  logic                               obi_err_i
);

    localparam int unsigned CntW = $clog2(4*MaxWords+1);
    localparam int unsigned WcW  = $clog2(MaxWords);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [29:0]     base_q,  base_d;   // word-aligned base (byte address >> 2)
    logic [WcW-1:0]  wcnt_q,  wcnt_d;
    logic [1:0]      idx_q,   idx_d;
    logic [31:0]     word_q,  word_d;
    logic            abort_q, abort_d;
    logic            err_q,   err_d;
    logic [CntW-1:0] cnt_q,   cnt_d;

    logic [7:0]      cur_byte;
    logic            last_word;
    logic            w_unused_addr_bits;

    // The two low address bits are dropped: fetches are always word aligned.
    assign w_unused_addr_bits = ^base_addr_i[1:0];

    assign cur_byte  = word_q[{idx_q, 3'b000} +: 8];
    assign last_word = (wcnt_q == WcW'(MaxWords - 1));
    assign count_o   = cnt_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wcnt_d       = wcnt_q;
        idx_d        = idx_q;
        word_d       = word_q;
        abort_d      = abort_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        obi_req_o    = 1'b0;
        obi_we_o     = 1'b0;
        obi_be_o     = 4'h0;
        obi_addr_o   = 32'h0;
        obi_aid_o    = '0;
        byte_o       = 8'h00;
        byte_valid_o = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        err_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_o  = 1'b0;
                abort_d = 1'b0;
                err_d   = 1'b0;
                if (start_i) begin
                    base_d  = base_addr_i[31:2];
                    wcnt_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // Address arithmetic on the word address wraps modulo 2^32 bytes.
                obi_req_o  = 1'b1;
                obi_be_o   = 4'hF;
                obi_addr_o = {base_q + {{(30-WcW){1'b0}}, wcnt_q}, 2'b00};
                if (abort_i) begin
                    abort_d = 1'b1;
                end
                if (obi_gnt_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (abort_i) begin
                    abort_d = 1'b1;
                end
                if (obi_rvalid_i) begin
                    // An error response wins over a pending or concurrent abort.
                    if (obi_err_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (abort_q || abort_i) begin
                        state_d = S_DONE;
                    end else begin
                        word_d  = obi_rdata_i;
                        idx_d   = 2'd0;
                        state_d = S_EMIT;
                    end
                end
            end

            S_EMIT: begin
                byte_o       = cur_byte;
                byte_valid_o = (cur_byte != 8'h00);
                if (cur_byte == 8'h00) begin
                    state_d = S_DONE;
                end else if (byte_ready_i) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        idx_d   = 2'd0;
                        wcnt_d  = wcnt_q + WcW'(1);
                        state_d = last_word ? S_DONE : S_REQ;
                    end
                end
                // Abort ends the transfer next edge; a same-cycle handshake still counts.
                if (abort_i) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                abort_d = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
